// File: rtl/sram_arbiter_if.sv
// Requester-side and sram-side signals of the two-port sram arbiter.
// The arbiter uses the slave view; requesters use master, the sram uses mem.
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic              lock0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic              lock1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DATA_W-1:0] rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata
    );

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_dout,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_we, mem_addr, mem_din
    );

    modport mem (
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port sram between the processor port (0) and the debug/DMA
// port (1): combinational grant, optional lock, read-return tagging, contention count.
module sram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus,
    output logic [15:0]   contention_cnt
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    owner_e            lock_q, lock_d;
    logic              last_gnt_q, last_gnt_d;
    logic [15:0]       cnt_q, cnt_d;
    rd_tag_t           rd_tag_q [READ_LATENCY];
    rd_tag_t           rd_tag_d;
    logic              win0, win1;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] din_sel;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (!reset) begin
            if (lock_q == OWN_P0 && bus.req0) begin
                win0 = 1'b1;
            end else if (lock_q == OWN_P1 && bus.req1) begin
                win1 = 1'b1;
            end else if (bus.req0 && bus.req1) begin
                // last_gnt_q == 1 means port 1 won last, so port 0 takes the tie
                if (FIXED_PRIO != 0 || last_gnt_q) win0 = 1'b1;
                else                               win1 = 1'b1;
            end else begin
                win0 = bus.req0;
                win1 = bus.req1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_d     = OWN_NONE;
        rd_tag_d   = '0;
        we_sel     = 1'b0;
        addr_sel   = '0;
        din_sel    = '0;
        cnt_d      = cnt_q;
        // With no winner the owner (if any) has dropped req, so the lock falls away.
        if (win0) begin
            last_gnt_d     = 1'b0;
            lock_d         = bus.lock0 ? OWN_P0 : OWN_NONE;
            we_sel         = bus.we0;
            addr_sel       = bus.addr0;
            din_sel        = bus.wdata0;
            rd_tag_d.valid = !bus.we0;
            rd_tag_d.port  = 1'b0;
        end else if (win1) begin
            last_gnt_d     = 1'b1;
            lock_d         = bus.lock1 ? OWN_P1 : OWN_NONE;
            we_sel         = bus.we1;
            addr_sel       = bus.addr1;
            din_sel        = bus.wdata1;
            rd_tag_d.valid = !bus.we1;
            rd_tag_d.port  = 1'b1;
        end
        if (bus.req0 && bus.req1 && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= OWN_NONE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            // NOTE: the tag pipeline is reset (unlike a data memory) because a
            // stale valid bit would fire an rvalid for a read dropped by reset.
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_tag_q[i] <= '0;
            end
        end else begin
            lock_q      <= lock_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            rd_tag_q[0] <= rd_tag_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_tag_q[i] <= rd_tag_q[i-1];
            end
        end
    end

    assign bus.gnt0    = win0;
    assign bus.gnt1    = win1;
    assign bus.rvalid0 = rd_tag_q[READ_LATENCY-1].valid & ~rd_tag_q[READ_LATENCY-1].port & ~reset;
    assign bus.rvalid1 = rd_tag_q[READ_LATENCY-1].valid &  rd_tag_q[READ_LATENCY-1].port & ~reset;
    assign bus.rdata   = bus.mem_dout;

    assign bus.mem_we   = we_sel;
    assign bus.mem_addr = addr_sel;
    assign bus.mem_din  = din_sel;

    assign contention_cnt = cnt_q;
endmodule
